// File: rtl/uart_mvm_core.sv
// -----------------------------------------------------------------------------
// uart_mvm_core
//
// UART-driven 2x2 signed matrix-vector multiplier in a TinyTapeout-style pin
// wrapper. A 3-byte frame carrying vector x and matrix K arrives on the RX
// line. The core computes y = K*x and sends y[0], then y[1], on the TX line.
// RX and TX run independently, so a new frame may arrive while the previous
// reply is still being sent.
//
// Frame layout (first received byte in bits 7:0 of the assembled bus):
//   byte0 = {x1, x0}, byte1 = {K01, K00}, byte2 = {K11, K10}
//
// Ports:
//   clk      system clock, single clock domain
//   rst      synchronous, active-high reset
//   ena      design enable, ignored
//   ui_in    bit 0 = UART RX line (idle high), bits 7:1 unused
//   uo_out   bit 0 = UART TX line (idle high), bits 7:1 driven 0
//   uio_in   unused
//   uio_out  constant 0
//   uio_oe   constant 0 (all bidirectional pins are inputs)
//
// Optional feature (macro UART_MVM_SAT_EN):
//   defined   - each y[r] saturates to [-128, 127] before transmission
//   undefined - y[r] is the low 8 bits of the full sum (two's-complement wrap)
// -----------------------------------------------------------------------------
module uart_mvm_core #(
  parameter int CLOCKS_PER_PULSE = 32,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE_TX   = 13,
  parameter int R                = 2,
  parameter int C                = 2,
  parameter int W_X              = 4,
  parameter int W_K              = 4,
  parameter int W_Y_OUT          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int N_WORDS_KX = (R * C * W_K + C * W_X) / BITS_PER_WORD;
  localparam int W_FRAME    = N_WORDS_KX * BITS_PER_WORD;
  localparam int W_Y_FULL   = W_X + W_K + $clog2(C);
  localparam int CW         = $clog2(CLOCKS_PER_PULSE);
  localparam int BW         = $clog2(BITS_PER_WORD);
  localparam int WCW        = $clog2(N_WORDS_KX + 1);
  localparam int N_PAD      = PACKET_SIZE_TX - 1 - BITS_PER_WORD;
  localparam int N_TX_BITS  = R * PACKET_SIZE_TX;
  localparam int TBW        = $clog2(N_TX_BITS);

  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BW-1:0]  DATA_LAST = BW'(BITS_PER_WORD - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(N_WORDS_KX - 1);
  localparam logic [TBW-1:0] TX_LAST   = TBW'(N_TX_BITS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;

  // ---------------------------------------------------------------------------
  // RX line synchronizer (idle level is high, so it resets to 1)
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= ui_in[0];
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM: half-bit start check, mid-bit data sampling, stop-bit validation.
  // rx_valid is a one-cycle pulse with the received byte in rx_byte.
  // ---------------------------------------------------------------------------
  rx_state_t                  rx_state;
  logic [CW-1:0]              rx_cnt;
  logic [BW-1:0]              rx_bit;
  logic [BITS_PER_WORD-1:0]   rx_shift;
  logic [BITS_PER_WORD-1:0]   rx_byte;
  logic                       rx_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            // Still low at mid start bit: a real start. High: a glitch.
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            // LSB arrives first, so shift in from the top.
            rx_shift <= {rx_sync, rx_shift[BITS_PER_WORD-1:1]};
            if (rx_bit == DATA_LAST) rx_state <= RX_STOP;
            else                     rx_bit   <= rx_bit + BW'(1);
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            // A low stop bit is a framing error: the byte is dropped silently.
            if (rx_sync) begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame assembly and y = K*x
  // frame_cur is the frame buffer with the byte currently on rx_byte merged in,
  // so the product is ready in the same cycle the last byte becomes valid.
  // ---------------------------------------------------------------------------
  logic [W_FRAME-1:0]             frame_buf;
  logic [W_FRAME-1:0]             frame_cur;
  logic [WCW-1:0]                 byte_cnt;
  logic [W_X-1:0]                 x_v;
  logic [W_K-1:0]                 k_v;
  logic [W_Y_FULL-1:0]            x_e, k_e;
  logic [R-1:0][W_Y_FULL-1:0]     y_full;
  logic [R*W_Y_OUT-1:0]           y_word;
`ifdef UART_MVM_SAT_EN
  logic [W_Y_FULL-W_Y_OUT:0]      y_hi;
`endif

  // NOTE: every variable of a combinational block gets a default first, so no
  // path through the block can leave it holding state (no inferred latch).
  always_comb begin
    frame_cur = frame_buf;
    frame_cur[byte_cnt*BITS_PER_WORD +: BITS_PER_WORD] = rx_byte;
    x_v    = '0;
    k_v    = '0;
    x_e    = '0;
    k_e    = '0;
    y_full = '0;
    y_word = '0;
`ifdef UART_MVM_SAT_EN
    y_hi   = '0;
`endif
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        x_v = frame_cur[c*W_X +: W_X];
        k_v = frame_cur[C*W_X + (r*C + c)*W_K +: W_K];
        // Sign-extend to the full sum width; the low W_Y_FULL bits of a
        // two's-complement product do not depend on operand signedness.
        x_e = {{(W_Y_FULL-W_X){x_v[W_X-1]}}, x_v};
        k_e = {{(W_Y_FULL-W_K){k_v[W_K-1]}}, k_v};
        y_full[r] = y_full[r] + x_e * k_e;
      end
`ifdef UART_MVM_SAT_EN
      // Fits in W_Y_OUT bits only if all bits above the output sign agree.
      y_hi = y_full[r][W_Y_FULL-1:W_Y_OUT-1];
      if ((&y_hi) || !(|y_hi))
        y_word[r*W_Y_OUT +: W_Y_OUT] = y_full[r][W_Y_OUT-1:0];
      else if (y_full[r][W_Y_FULL-1])
        y_word[r*W_Y_OUT +: W_Y_OUT] = {1'b1, {(W_Y_OUT-1){1'b0}}};
      else
        y_word[r*W_Y_OUT +: W_Y_OUT] = {1'b0, {(W_Y_OUT-1){1'b1}}};
`else
      y_word[r*W_Y_OUT +: W_Y_OUT] = y_full[r][W_Y_OUT-1:0];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Byte counter, frame buffer and single-entry pending result
  // ---------------------------------------------------------------------------
  logic [R*W_Y_OUT-1:0] pend_y;
  logic                 pend_valid;
  logic                 tx_load;
  tx_state_t            tx_state;

  assign tx_load = (tx_state == TX_IDLE) && pend_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the frame buffer is only a few flops and is cleared on reset so
      // bytes of an interrupted frame can never combine with a later one.
      frame_buf  <= '0;
      byte_cnt   <= '0;
      pend_y     <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (rx_valid) begin
        frame_buf <= frame_cur;
        if (byte_cnt == WORD_LAST) byte_cnt <= '0;
        else                       byte_cnt <= byte_cnt + WCW'(1);
      end
      // A fresh result wins over a hand-off in the same cycle and overwrites
      // any result that has not been picked up yet.
      if (rx_valid && (byte_cnt == WORD_LAST)) begin
        pend_y     <= y_word;
        pend_valid <= 1'b1;
      end else if (tx_load) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX: all result words are packed into one LSB-first bit stream, each word
  // being {N_PAD ones, data, start 0}, so words go out back to back.
  // ---------------------------------------------------------------------------
  logic [N_TX_BITS-1:0]   tx_packet;
  logic [N_TX_BITS-2:0]   tx_shift;
  logic [CW-1:0]          tx_cnt;
  logic [TBW-1:0]         tx_bit;
  logic                   tx_line;

  always_comb begin
    tx_packet = '0;
    for (int r = 0; r < R; r++)
      tx_packet[r*PACKET_SIZE_TX +: PACKET_SIZE_TX] =
        {{N_PAD{1'b1}}, pend_y[r*W_Y_OUT +: W_Y_OUT], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_line  <= 1'b1;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          tx_line <= 1'b1;
          if (tx_load) begin
            tx_line  <= tx_packet[0];
            tx_shift <= tx_packet[N_TX_BITS-1:1];
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == TX_LAST) begin
              tx_line  <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_bit   <= tx_bit + TBW'(1);
              tx_line  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pin wrapper
  // ---------------------------------------------------------------------------
  assign uo_out  = {7'b0, tx_line};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Inputs the wrapper ignores, plus sum bits that only matter for saturation.
  logic unused;
  assign unused = &{1'b0, ena, ui_in[7:1], uio_in, y_full};

endmodule

// File: tb/tb_uart_mvm_core.sv
// -----------------------------------------------------------------------------
// tb_uart_mvm_core
//
// Bench for uart_mvm_core. A UART driver sends frames on ui_in[0]; a monitor
// decodes uo_out[0] into a byte queue and checks start/padding bits. Expected
// replies are hand-computed constants in a vector table.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_mvm_core;

  localparam int CPP = 32;
  localparam int N_VEC = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       rx_line;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign ui_in = {7'h55, rx_line};

  always #5 clk = ~clk;

  uart_mvm_core dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] mon_byte;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         gap;
    logic [7:0] y0, y1;
  } vec_t;

  vec_t vecs[N_VEC];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // TX monitor: samples each bit at its middle, on the falling clock edge.
  // ---------------------------------------------------------------------------
  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uo_out[0] === 1'b0) begin
        repeat (CPP/2) @(negedge clk);
        check("tx_start_bit", {31'b0, uo_out[0]}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPP) @(negedge clk);
          mon_byte[i] = uo_out[0];
        end
        for (int i = 0; i < 4; i++) begin
          repeat (CPP) @(negedge clk);
          check("tx_pad_bit", {31'b0, uo_out[0]}, 32'd1);
        end
        tx_q.push_back(mon_byte);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx_line = 1'b0;
    idle(CPP);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      idle(CPP);
    end
    rx_line = stop_bit;
    idle(CPP);
    rx_line = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_bytes(input string name, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (tx_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(name, tx_q.size(), n);
  endtask

  task automatic expect_byte(input string name, input logic [7:0] exp);
    if (tx_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no byte, expected 0x%0h", name, exp);
    end else begin
      check(name, {24'b0, tx_q.pop_front()}, {24'b0, exp});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] y_m8;
`ifdef UART_MVM_SAT_EN
    y_m8 = 8'h7F;
`else
    y_m8 = 8'h80;
`endif
    //           b0     b1     b2   gap   y0     y1
    vecs[0]  = '{8'h32, 8'hF1, 8'h54,  37, 8'hFF, 8'h17};
    vecs[1]  = '{8'h88, 8'h88, 8'h88,   1, y_m8,  y_m8 };
    vecs[2]  = '{8'h00, 8'h00, 8'h00, 100, 8'h00, 8'h00};
    vecs[3]  = '{8'h11, 8'h11, 8'h11,  12, 8'h02, 8'h02};
    vecs[4]  = '{8'h77, 8'h77, 8'h77,  55, 8'h62, 8'h62};
    vecs[5]  = '{8'h87, 8'h77, 8'h88,   3, 8'hF9, 8'h08};
    vecs[6]  = '{8'h7F, 8'h12, 8'hA3,  80, 8'h05, 8'hD3};
    vecs[7]  = '{8'h8F, 8'h78, 8'h87,  20, 8'hD0, 8'h39};
    vecs[8]  = '{8'h45, 8'h36, 8'hC2,  64, 8'h2A, 8'hFA};
    vecs[9]  = '{8'h9B, 8'hE4, 8'h6D,   9, 8'hFA, 8'hE5};
    vecs[10] = '{8'h0C, 8'hF8, 8'h51,  45, 8'h20, 8'hFC};
    vecs[11] = '{8'h80, 8'h80, 8'h08,   2, 8'h40, 8'h00};

    rst     = 1'b1;
    ena     = 1'b1;
    rx_line = 1'b1;
    uio_in  = 8'hA5;
    idle(4);
    check("reset_uo_out", {24'b0, uo_out}, 32'h01);
    check("reset_uio_out", {24'b0, uio_out}, 32'h00);
    check("reset_uio_oe", {24'b0, uio_oe}, 32'h00);
    rst = 1'b0;
    idle(10);
    check("idle_tx_high", {24'b0, uo_out}, 32'h01);

    // Table: frames back to back with short gaps; each frame arrives while the
    // previous reply is still on the TX line.
    for (int i = 0; i < N_VEC; i++) begin
      send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      idle(vecs[i].gap);
    end
    wait_bytes("table_reply_count", 2 * N_VEC, 4000);
    for (int i = 0; i < N_VEC; i++) begin
      expect_byte($sformatf("vec%0d_y0", i), vecs[i].y0);
      expect_byte($sformatf("vec%0d_y1", i), vecs[i].y1);
    end

    // Framing error on the second byte: that byte is dropped and the counter
    // stays put, so 0x32, 0xF1, 0x54 still form one frame.
    pulse_reset();
    tx_q.delete();
    idle(20);
    send_byte(8'h32, 1'b1);
    send_byte(8'hAA, 1'b0);
    idle(2 * CPP);
    send_byte(8'hF1, 1'b1);
    send_byte(8'h54, 1'b1);
    wait_bytes("framing_reply_count", 2, 2000);
    expect_byte("framing_y0", 8'hFF);
    expect_byte("framing_y1", 8'h17);
    idle(1200);
    check("framing_no_extra_reply", tx_q.size(), 0);

    // Reset after 1.5 received bytes: partial frame is discarded.
    send_byte(8'h32, 1'b1);
    @(negedge clk);
    rx_line = 1'b0;
    idle(CPP);
    for (int i = 0; i < 4; i++) begin
      rx_line = 1'(8'hF1 >> i);
      idle(CPP);
    end
    rst = 1'b1;
    @(negedge clk);
    check("tx_high_in_reset", {31'b0, uo_out[0]}, 32'd1);
    rst     = 1'b0;
    rx_line = 1'b1;
    idle(3 * CPP);
    send_frame(8'h32, 8'hF1, 8'h54);
    wait_bytes("midreset_reply_count", 2, 2000);
    expect_byte("midreset_y0", 8'hFF);
    expect_byte("midreset_y1", 8'h17);
    idle(1200);
    check("midreset_no_extra_reply", tx_q.size(), 0);

    // One-cycle low glitch while idle: no byte accepted, no TX activity.
    @(negedge clk);
    rx_line = 1'b0;
    @(negedge clk);
    rx_line = 1'b1;
    idle(1500);
    check("glitch_no_tx", tx_q.size(), 0);
    send_frame(8'h11, 8'h11, 8'h11);
    wait_bytes("glitch_reply_count", 2, 2000);
    expect_byte("glitch_y0", 8'h02);
    expect_byte("glitch_y1", 8'h02);

    idle(50);
    check("final_tx_idle", {24'b0, uo_out}, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
